// File: rtl/lsu_unaligned_if.sv
// Core-side request/response channel of the load/store unit.
// The core owns the master modport; the LSU owns the slave modport.
interface lsu_unaligned_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_unaligned.sv
// RV32I load/store unit driving an aligned word-organised dmem with byte enables.
// Word-crossing accesses are split into two aligned word accesses and load data is merged.
module lsu_unaligned #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    lsu_unaligned_if.slave        core,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           buf0;
    logic [31:0]           buf1;
    logic [31:0]           rdata_hold;
    logic                  err_hold;

    logic                  accept;
    logic [1:0]            offset;
    logic [2:0]            size_bytes;
    logic                  split;
    logic [7:0]            lane_mask;
    logic [7:0]            be64;
    logic [63:0]           wd64;
    logic [WW-1:0]         word_addr;
    logic [WW-1:0]         word_addr_next;
    logic [31:0]           shifted;
    logic [31:0]           load_ext;
    logic [31:0]           rdata_now;
    logic                  resp_live;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] || (f3[1:0] == 2'b11);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    assign accept = core.req_valid && (state == IDLE);

    // Access geometry derived from the latched request.
    always_comb begin
        offset     = addr_q[1:0];
        size_bytes = 3'd4;
        lane_mask  = 8'h0F;
        case (f3_q[1:0])
            2'b00: begin
                size_bytes = 3'd1;
                lane_mask  = 8'h01;
            end
            2'b01: begin
                size_bytes = 3'd2;
                lane_mask  = 8'h03;
            end
            default: begin
                size_bytes = 3'd4;
                lane_mask  = 8'h0F;
            end
        endcase
        split          = (3'(offset) + size_bytes) > 3'd4;
        be64           = lane_mask << offset;
        wd64           = {32'h0, wdata_q} << {offset, 3'b000};
        word_addr      = addr_q[ADDR_WIDTH-1:2];
        word_addr_next = word_addr + WW'(1);
    end

    // Merge the two captured words, align to the access and extend per funct3.
    always_comb begin
        shifted  = 32'({buf1, buf0} >> {offset, 3'b000});
        load_ext = shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        rdata_now = (we_q || err_q) ? 32'h0 : load_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            buf0       <= 32'h0;
            buf1       <= 32'h0;
            rdata_hold <= 32'h0;
            err_hold   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= core.req_we;
                f3_q    <= core.req_funct3;
                addr_q  <= core.req_addr;
                wdata_q <= core.req_wdata;
                err_q   <= is_illegal(core.req_we, core.req_funct3);
            end
            if (state == ACC0 && !we_q)
                buf0 <= mem_rdata;
            if (state == ACC1 && !we_q)
                buf1 <= mem_rdata;
            if (state == RESP) begin
                rdata_hold <= rdata_now;
                err_hold   <= err_q;
            end
        end
    end

    // Next state and dmem drive; reset suppresses any access in the current cycle.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_be     = 4'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                if (core.req_valid)
                    state_next = is_illegal(core.req_we, core.req_funct3) ? RESP : ACC0;
            end
            ACC0: begin
                mem_addr   = word_addr;
                mem_rd_en  = !we_q;
                mem_wr_en  = we_q;
                mem_be     = be64[3:0];
                mem_wdata  = wd64[31:0];
                state_next = split ? ACC1 : RESP;
            end
            ACC1: begin
                mem_addr   = word_addr_next;
                mem_rd_en  = !we_q;
                mem_wr_en  = we_q;
                mem_be     = be64[7:4];
                mem_wdata  = wd64[63:32];
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            mem_addr  = '0;
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
            mem_be    = 4'h0;
            mem_wdata = 32'h0;
        end
    end

    assign resp_live       = (state == RESP) && !reset;
    assign core.req_ready  = (state == IDLE);
    assign core.resp_valid = resp_live;
    assign core.resp_err   = resp_live ? err_q : err_hold;
    assign core.resp_rdata = resp_live ? rdata_now : rdata_hold;

endmodule

// File: tb/tb_lsu_unaligned.sv
// Testbench for lsu_unaligned: directed vector table, multi-cycle corner sequences,
// and random transactions checked against a byte-addressed memory model.
module tb_lsu_unaligned;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_unaligned_if #(.ADDR_WIDTH(AW)) bus ();

    logic [AW-3:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    lsu_unaligned #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .core      (bus),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic [31:0] dmem [1024];
    logic [7:0]  ref_mem [4096];
    acc_t        acc_log [$];
    vec_t        vecs [$];

    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = 10'h0;
    logic [31:0] bd_data = 32'h0;

    int total = 0;
    int bad = 0;

    logic [31:0] a_rd, m_rd;
    logic        a_err, m_err;
    int          a_lat, m_lat;
    int          base;

    assign mem_rdata = dmem[mem_addr];

    // dmem: combinational read, byte-enabled write at posedge, plus a backdoor preload port.
    always @(posedge clk) begin
        if (mem_wr_en)
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) dmem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        if (mem_rd_en || mem_wr_en)
            acc_log.push_back('{mem_addr, mem_be, mem_wdata, mem_wr_en});
        if (bd_we)
            dmem[bd_addr] <= bd_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic write_word(input int w, input logic [31:0] v);
        bd_addr = 10'(w);
        bd_data = v;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        for (int l = 0; l < 4; l++) ref_mem[12'(4*w + l)] = v[8*l +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[12'(4*w+3)], ref_mem[12'(4*w+2)], ref_mem[12'(4*w+1)], ref_mem[12'(4*w)]};
    endfunction

    // Reference: byte-addressed little-endian memory, access rules stated as plain arithmetic.
    function automatic void ref_txn(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                                    input logic [31:0] wd, output logic [31:0] rd,
                                    output logic err, output int lat);
        int n;
        logic illegal;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = we ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        rd  = 32'h0;
        err = illegal;
        lat = 1;
        v   = 32'h0;
        if (illegal) return;
        lat = ((int'(addr) % 4) + n > 4) ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            if (we) ref_mem[12'((int'(addr) + i) % 4096)] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[12'((int'(addr) + i) % 4096)];
        end
        if (!we) begin
            if (n < 4 && !f3[2] && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    // Enter and leave at #1 after a posedge with the LSU idle.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic err, output int lat);
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = 12'($urandom);
        bus.req_wdata  = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.resp_valid) lat = 99;
        bus.req_valid = 1'b0;
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        @(posedge clk); #1;
        checkOutput("resp_strobe_drop", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 12'h0;
        bus.req_wdata  = 32'h0;

        // Reset values
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_mem_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < 1024; w++) write_word(w, $urandom);

        // SW aligned: one write
        base = acc_log.size();
        ref_txn(1'b1, 3'b010, 12'h004, 32'hDEADBEEF, m_rd, m_err, m_lat);
        applyStimulus(1'b1, 3'b010, 12'h004, 32'hDEADBEEF, a_rd, a_err, a_lat);
        checkOutput("sw_lat", 32'(a_lat), 32'd2);
        checkOutput("sw_err", 32'(a_err), 32'd0);
        checkOutput("sw_nacc", 32'(acc_log.size() - base), 32'd1);
        if (acc_log.size() > base) begin
            checkOutput("sw_addr", 32'(acc_log[base].addr), 32'h001);
            checkOutput("sw_be", 32'(acc_log[base].be), 32'hF);
            checkOutput("sw_wdata", acc_log[base].wdata, 32'hDEADBEEF);
        end
        checkOutput("sw_mem", dmem[1], 32'hDEADBEEF);

        // SH split across words 1/2
        base = acc_log.size();
        ref_txn(1'b1, 3'b001, 12'h007, 32'h0000ABCD, m_rd, m_err, m_lat);
        applyStimulus(1'b1, 3'b001, 12'h007, 32'h0000ABCD, a_rd, a_err, a_lat);
        checkOutput("sh_split_lat", 32'(a_lat), 32'd3);
        checkOutput("sh_split_nacc", 32'(acc_log.size() - base), 32'd2);
        if (acc_log.size() > base + 1) begin
            checkOutput("sh_acc0", {acc_log[base].wdata}, 32'hCD000000);
            checkOutput("sh_acc0_ab", {22'h0, acc_log[base].addr}, 32'h001);
            checkOutput("sh_acc0_be", 32'(acc_log[base].be), 32'h8);
            checkOutput("sh_acc1", acc_log[base+1].wdata, 32'h000000AB);
            checkOutput("sh_acc1_ab", {22'h0, acc_log[base+1].addr}, 32'h002);
            checkOutput("sh_acc1_be", 32'(acc_log[base+1].be), 32'h1);
        end

        // LW wrapping from the top word to word 0
        write_word(1023, 32'hAABBCCDD);
        write_word(0, 32'h11223344);
        base = acc_log.size();
        ref_txn(1'b0, 3'b010, 12'hFFE, 32'h0, m_rd, m_err, m_lat);
        applyStimulus(1'b0, 3'b010, 12'hFFE, 32'h0, a_rd, a_err, a_lat);
        checkOutput("lw_wrap_rdata", a_rd, 32'h3344AABB);
        checkOutput("lw_wrap_lat", 32'(a_lat), 32'd3);
        checkOutput("lw_wrap_nacc", 32'(acc_log.size() - base), 32'd2);
        if (acc_log.size() > base + 1) begin
            checkOutput("lw_wrap_a0", {22'h0, acc_log[base].addr}, 32'h3FF);
            checkOutput("lw_wrap_be0", 32'(acc_log[base].be), 32'hC);
            checkOutput("lw_wrap_a1", {22'h0, acc_log[base+1].addr}, 32'h000);
            checkOutput("lw_wrap_be1", 32'(acc_log[base+1].be), 32'h3);
        end

        // Directed vector table
        write_word(0, 32'h80123456);
        write_word(1, 32'h44332211);
        write_word(2, 32'h88776655);
        vecs.push_back('{1'b0, 3'b010, 12'h006, 32'h0, 32'h66554433, 1'b0, 3});
        vecs.push_back('{1'b0, 3'b000, 12'h003, 32'h0, 32'hFFFFFF80, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b100, 12'h003, 32'h0, 32'h00000080, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b001, 12'h002, 32'h0, 32'hFFFF8012, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b101, 12'h002, 32'h0, 32'h00008012, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b001, 12'h003, 32'h0, 32'h00001180, 1'b0, 3});
        vecs.push_back('{1'b0, 3'b001, 12'h001, 32'h0, 32'h00001234, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b010, 12'h000, 32'h0, 32'h80123456, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b011, 12'h000, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 3'b110, 12'h004, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 3'b100, 12'h004, 32'h5, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 3'b011, 12'h004, 32'h5, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 3'b010, 12'h101, 32'hCAFEF00D, 32'h0, 1'b0, 3});
        vecs.push_back('{1'b0, 3'b010, 12'h101, 32'h0, 32'hCAFEF00D, 1'b0, 3});
        vecs.push_back('{1'b0, 3'b100, 12'h104, 32'h0, 32'h000000CA, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b000, 12'h104, 32'h0, 32'hFFFFFFCA, 1'b0, 2});
        vecs.push_back('{1'b1, 3'b000, 12'h103, 32'h123456EE, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 3'b001, 12'h103, 32'h0, 32'hFFFFCAEE, 1'b0, 3});
        for (int i = 0; i < vecs.size(); i++) begin
            ref_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat);
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, a_rd, a_err, a_lat);
            checkOutput($sformatf("vec%0d_rdata", i), a_rd, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_lat", i), 32'(a_lat), 32'(vecs[i].exp_lat));
        end

        // Illegal load: no memory access, error held while idle
        base = acc_log.size();
        ref_txn(1'b0, 3'b111, 12'h010, 32'h0, m_rd, m_err, m_lat);
        applyStimulus(1'b0, 3'b111, 12'h010, 32'h0, a_rd, a_err, a_lat);
        checkOutput("ill_err", 32'(a_err), 32'd1);
        checkOutput("ill_lat", 32'(a_lat), 32'd1);
        checkOutput("ill_nacc", 32'(acc_log.size() - base), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ill_err_held", 32'(bus.resp_err), 32'd1);

        // Split SW with reset during the second access
        write_word(1, 32'h11111111);
        write_word(2, 32'h22222222);
        base = acc_log.size();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 12'h005;
        bus.req_wdata  = 32'hA1B2C3D4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rsplit_wr_gated", 32'(mem_wr_en), 32'd0);
        checkOutput("rsplit_no_resp0", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rsplit_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rsplit_err_clr", 32'(bus.resp_err), 32'd0);
        checkOutput("rsplit_rdata_clr", bus.resp_rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("rsplit_no_resp%0d", c + 1), 32'(bus.resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("rsplit_word1", dmem[1], 32'hB2C3D411);
        checkOutput("rsplit_word2", dmem[2], 32'h22222222);
        checkOutput("rsplit_nacc", 32'(acc_log.size() - base), 32'd1);
        ref_mem[12'h005] = 8'hD4;
        ref_mem[12'h006] = 8'hC3;
        ref_mem[12'h007] = 8'hB2;

        // Random transactions against the byte-level model
        for (int t = 0; t < 200; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [11:0] addr;
            logic [31:0] wd;
            int          w0;
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = 12'($urandom);
            wd   = $urandom;
            ref_txn(we, f3, addr, wd, m_rd, m_err, m_lat);
            applyStimulus(we, f3, addr, wd, a_rd, a_err, a_lat);
            checkOutput($sformatf("rnd%0d_rdata", t), a_rd, m_rd);
            checkOutput($sformatf("rnd%0d_err", t), 32'(a_err), 32'(m_err));
            checkOutput($sformatf("rnd%0d_lat", t), 32'(a_lat), 32'(m_lat));
            w0 = int'(addr) / 4;
            checkOutput($sformatf("rnd%0d_word0", t), dmem[10'(w0)], ref_word(w0));
            checkOutput($sformatf("rnd%0d_word1", t), dmem[10'((w0 + 1) % 1024)], ref_word((w0 + 1) % 1024));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
